// File: rtl/dram_fifo_ctrl.sv
// 32-entry FIFO controller driving an external RAM32M (sync write, async read) with a registered dout.
// Read latency 1 cycle; requests against full/empty are dropped and flagged by a one-cycle overflow/underflow pulse.
module dram_fifo_ctrl #(
  parameter logic [5:0] PROG_FULL_THRESH  = 6'd28,
  parameter logic [5:0] PROG_EMPTY_THRESH = 6'd4,
  parameter logic [5:0] DOUT_RESET        = 6'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] din,
  output logic       full,
  output logic       prog_full,
  output logic       overflow,
  input  logic       rd_en,
  output logic [5:0] dout,
  output logic       valid,
  output logic       empty,
  output logic       prog_empty,
  output logic       underflow,
  output logic [5:0] count,
  output logic       ram_we,
  output logic [4:0] ram_waddr,
  output logic [5:0] ram_wdata,
  output logic [4:0] ram_raddr,
  input  logic [5:0] ram_rdata
);

  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic       wr_acc;
  logic       rd_acc;

  // Extra pointer MSB distinguishes full from empty when the RAM addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[4:0] == rd_ptr[4:0]) && (wr_ptr[5] != rd_ptr[5]);
  assign count = wr_ptr - rd_ptr;

  assign prog_full  = (count >= PROG_FULL_THRESH);
  assign prog_empty = (count <= PROG_EMPTY_THRESH);

  // Gated by rst so the RAM is never written while reset is held.
  assign wr_acc = wr_en & ~full & ~rst;
  assign rd_acc = rd_en & ~empty & ~rst;

  assign ram_we    = wr_acc;
  assign ram_waddr = wr_ptr[4:0];
  assign ram_wdata = din;
  assign ram_raddr = rd_ptr[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= 6'd0;
      rd_ptr    <= 6'd0;
      dout      <= DOUT_RESET;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 6'd1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 6'd1;
        dout   <= ram_rdata;
      end
      valid     <= rd_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
// Randomized scoreboard bench for dram_fifo_ctrl with a behavioural RAM32M and a queue-based FIFO model.
module tb_dram_fifo_ctrl;
  localparam logic [5:0] PFT  = 6'd28;
  localparam logic [5:0] PET  = 6'd4;
  localparam logic [5:0] DRST = 6'h2A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [5:0] din = 6'd0;
  logic       full, prog_full, overflow, valid, empty, prog_empty, underflow;
  logic [5:0] dout, count;
  logic       ram_we;
  logic [4:0] ram_waddr, ram_raddr;
  logic [5:0] ram_wdata, ram_rdata;

  dram_fifo_ctrl #(
    .PROG_FULL_THRESH (PFT),
    .PROG_EMPTY_THRESH(PET),
    .DOUT_RESET       (DRST)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full), .prog_full(prog_full),
    .overflow(overflow), .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty),
    .prog_empty(prog_empty), .underflow(underflow), .count(count), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM32M: synchronous write, combinational read, contents survive reset.
  logic [5:0] mem [32];
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  typedef struct {
    logic       vld;
    logic [5:0] dout;
    logic       ovf;
    logic       unf;
    int         cnt;
  } rec_t;

  rec_t       rec_q[$];
  rec_t       mr;
  logic [5:0] mq[$];
  logic [5:0] last_dout;
  int         wr_idx, rd_idx;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its occupancy before the edge.
  task automatic cycle(input logic we, input logic re, input logic [5:0] d);
    bit   wa, ra;
    rec_t r;
    @(negedge clk);
    wr_en = we; rd_en = re; din = d;
    wa = we && (mq.size() < 32);
    ra = re && (mq.size() > 0);
    #1;
    chk("ram_we", int'(ram_we), int'(wa));
    chk("ram_waddr", int'(ram_waddr), wr_idx);
    chk("ram_raddr", int'(ram_raddr), rd_idx);
    if (wa) chk("ram_wdata", int'(ram_wdata), int'(d));
    r.ovf = we && !wa;
    r.unf = re && !ra;
    @(posedge clk);
    if (ra) begin
      last_dout = mq.pop_front();
      rd_idx = (rd_idx + 1) % 32;
    end
    if (wa) begin
      mq.push_back(d);
      wr_idx = (wr_idx + 1) % 32;
    end
    r.vld  = ra;
    r.dout = last_dout;
    r.cnt  = mq.size();
    rec_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (!rst && rec_q.size() > 0) begin
      mr = rec_q.pop_front();
      chk("valid", int'(valid), int'(mr.vld));
      chk("dout", int'(dout), int'(mr.dout));
      chk("overflow", int'(overflow), int'(mr.ovf));
      chk("underflow", int'(underflow), int'(mr.unf));
      chk("count", int'(count), mr.cnt);
      chk("empty", int'(empty), int'(mr.cnt == 0));
      chk("full", int'(full), int'(mr.cnt == 32));
      chk("prog_full", int'(prog_full), int'(mr.cnt >= 28));
      chk("prog_empty", int'(prog_empty), int'(mr.cnt <= 4));
    end
  end

  // Reset raised between edges with both requests active; outputs must clear before any edge.
  task automatic async_reset();
    #3;
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 6'h3F;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_dout", int'(dout), int'(DRST));
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_prog_empty", int'(prog_empty), 1);
    chk("rst_prog_full", int'(prog_full), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    mq.delete();
    rec_q.delete();
    last_dout = DRST;
    wr_idx = 0;
    rd_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_count", int'(count), 0);
    chk("rst_hold_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int pw, pr;
    foreach (mem[i]) mem[i] = 6'($urandom);
    async_reset();

    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 6'(i));
    repeat (3) cycle(1'b0, 1'b1, 6'd0);
    cycle(1'b0, 1'b0, 6'd0);

    // Fill to full, overflow, simultaneous ops at full, drain past empty, simultaneous ops at empty.
    repeat (32) cycle(1'b1, 1'b0, 6'($urandom));
    cycle(1'b1, 1'b0, 6'($urandom));
    cycle(1'b1, 1'b1, 6'($urandom));
    cycle(1'b1, 1'b0, 6'($urandom));
    repeat (33) cycle(1'b0, 1'b1, 6'd0);
    cycle(1'b0, 1'b1, 6'd0);
    cycle(1'b1, 1'b1, 6'($urandom));
    cycle(1'b0, 1'b1, 6'd0);
    cycle(1'b0, 0, 6'd0);

    // Steady stream at occupancy 16 across several pointer wraps.
    repeat (16) cycle(1'b1, 1'b0, 6'($urandom));
    repeat (100) cycle(1'b1, 1'b1, 6'($urandom));
    repeat (16) cycle(1'b0, 1'b1, 6'd0);

    // Random traffic with phases biased toward full and toward empty.
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 25;
      pr = (ph % 2 == 0) ? 25 : 80;
      repeat (100)
        cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 6'($urandom));
    end

    // Mid-stream reset at occupancy 10, then stale data must not surface.
    async_reset();
    repeat (10) cycle(1'b1, 1'b0, 6'($urandom));
    repeat (20) cycle(1'b1, 1'b1, 6'($urandom));
    async_reset();
    cycle(1'b0, 1'b1, 6'd0);
    cycle(1'b1, 1'b0, 6'h15);
    cycle(1'b0, 1'b1, 6'd0);
    cycle(1'b0, 1'b0, 6'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
